// File: rtl/sha256_ctrl_pkg.sv
// Shared constants and types for the SHA-256 engine control slice.
package sha256_ctrl_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned JOBS_W         = 16;
  localparam int unsigned WD_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_j;

  // Walk N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = ptr;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!valid && req[w_j]) begin
        valid = 1'b1;
        idx   = w_j;
      end
      w_j = (w_j == IDX_W'(N_REQ - 1)) ? '0 : w_j + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_job_arbiter.sv
// Round-robin job arbiter sharing one SHA-256 engine between N_REQ requesters,
// with start/done handshake tracking and a hang watchdog.
module sha256_job_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter  int unsigned N_REQ        = 4,
  parameter  int unsigned ADDR_W       = ADDR_W_DEFAULT,
  parameter  int unsigned TIMEOUT      = 2048,
  parameter  int unsigned BUSY_TIMEOUT = 4,
  localparam int unsigned GID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] msg_addr,
  input  logic [N_REQ*ADDR_W-1:0] out_addr,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        err,
  output logic                    eng_start,
  output logic [ADDR_W-1:0]       eng_message_addr,
  output logic [ADDR_W-1:0]       eng_output_addr,
  input  logic                    eng_done,
  output logic                    busy,
  output logic [GID_W-1:0]        grant_id,
  output logic [JOBS_W-1:0]       jobs_done
);

  arb_state_t        r_state;
  logic [GID_W-1:0]  r_ptr;
  logic [GID_W-1:0]  r_grant_id;
  logic [WD_W-1:0]   r_wd;
  logic [JOBS_W-1:0] r_jobs;
  logic [N_REQ-1:0]  r_ack;
  logic [N_REQ-1:0]  r_err;
  logic              r_eng_start;
  logic              r_busy;
  logic [ADDR_W-1:0] r_msg_addr;
  logic [ADDR_W-1:0] r_out_addr;

  logic              w_valid;
  logic [GID_W-1:0]  w_idx;
  logic [N_REQ-1:0]  w_grant_oh;
  logic [GID_W-1:0]  w_ptr_nxt;
  logic [WD_W-1:0]   w_wd_inc;
  logic [JOBS_W-1:0] w_jobs_inc;
  logic [ADDR_W-1:0] w_msg [N_REQ];
  logic [ADDR_W-1:0] w_out [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_msg[g] = msg_addr[g*ADDR_W +: ADDR_W];
    assign w_out[g] = out_addr[g*ADDR_W +: ADDR_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (GID_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // Helper values: grant one-hot, wrapped pointer advance, saturating increments.
  always_comb begin
    w_grant_oh             = '0;
    w_grant_oh[r_grant_id] = 1'b1;
    w_ptr_nxt  = (r_grant_id == GID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    w_wd_inc   = (r_wd == '1) ? r_wd : r_wd + 1'b1;
    w_jobs_inc = (r_jobs == '1) ? r_jobs : r_jobs + 1'b1;
  end

  // Job FSM; every output is a register updated together with the state so
  // start, ack and err line up with the ISSUE and RESP / timeout edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_wd        <= '0;
      r_jobs      <= '0;
      r_ack       <= '0;
      r_err       <= '0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
      r_msg_addr  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_ack       <= '0;
      r_err       <= '0;
      r_eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid && eng_done) begin
            r_grant_id  <= w_idx;
            r_msg_addr  <= w_msg[w_idx];
            r_out_addr  <= w_out[w_idx];
            r_eng_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wd    <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!eng_done) begin
            r_wd    <= '0;
            r_state <= ST_WAIT_DONE;
          end else if (r_wd == WD_W'(BUSY_TIMEOUT)) begin
            r_err   <= w_grant_oh;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        ST_WAIT_DONE: begin
          if (eng_done) begin
            r_ack   <= w_grant_oh;
            r_jobs  <= w_jobs_inc;
            r_state <= ST_RESP;
          end else if (r_wd == WD_W'(TIMEOUT)) begin
            r_err   <= w_grant_oh;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        ST_RESP: begin
          r_ptr   <= w_ptr_nxt;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack              = r_ack;
  assign err              = r_err;
  assign eng_start        = r_eng_start;
  assign eng_message_addr = r_msg_addr;
  assign eng_output_addr  = r_out_addr;
  assign busy             = r_busy;
  assign grant_id         = r_grant_id;
  assign jobs_done        = r_jobs;

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Directed bench for sha256_job_arbiter with a behavioural engine stub.
module tb_sha256_job_arbiter;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned TIMEOUT      = 40;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_IGNORE = 1;
  localparam int MODE_HANG   = 2;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] msg_addr;
  logic [N_REQ*ADDR_W-1:0] out_addr;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        err;
  logic                    eng_start;
  logic [ADDR_W-1:0]       eng_message_addr;
  logic [ADDR_W-1:0]       eng_output_addr;
  logic                    eng_done = 1'b1;
  logic                    busy;
  logic [1:0]              grant_id;
  logic [15:0]             jobs_done;

  int eng_mode;
  int eng_lat;
  int eng_cnt;
  int cycle = 0;
  int multi = 0;
  int n_vec = 0;
  int n_err = 0;
  int t0;
  int nst;

  always #5 clk = ~clk;

  sha256_job_arbiter #(
    .N_REQ        (N_REQ),
    .ADDR_W       (ADDR_W),
    .TIMEOUT      (TIMEOUT),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (req),
    .msg_addr         (msg_addr),
    .out_addr         (out_addr),
    .ack              (ack),
    .err              (err),
    .eng_start        (eng_start),
    .eng_message_addr (eng_message_addr),
    .eng_output_addr  (eng_output_addr),
    .eng_done         (eng_done),
    .busy             (busy),
    .grant_id         (grant_id),
    .jobs_done        (jobs_done)
  );

  // Engine stub: done falls the cycle after start, rises eng_lat cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (eng_start && eng_mode != MODE_IGNORE) begin
      eng_done <= 1'b0;
      eng_cnt  <= eng_lat;
    end else if (!eng_done && eng_mode == MODE_NORMAL) begin
      if (eng_cnt <= 1) eng_done <= 1'b1;
      eng_cnt <= eng_cnt - 1;
    end
  end

  always @(posedge clk) cycle++;

  // ack and err together must never have more than one bit set.
  always @(negedge clk) if ($countones(ack | err) > 1) multi++;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!eng_start && c < 200);
  endtask

  task automatic wait_resp();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((ack | err) == '0 && c < 200);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    req      = '0;
    msg_addr = '0;
    out_addr = '0;
    eng_mode = MODE_NORMAL;
    eng_lat  = 6;
    repeat (2) @(negedge clk);

    check_vec("rst_busy",   {31'd0, busy}, 32'd0);
    check_vec("rst_start",  {31'd0, eng_start}, 32'd0);
    check_vec("rst_gid",    {30'd0, grant_id}, 32'd0);
    check_vec("rst_jobs",   {16'd0, jobs_done}, 32'd0);
    check_vec("rst_ackerr", {24'd0, ack, err}, 32'd0);
    check_vec("rst_addr",   {eng_message_addr, eng_output_addr}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // single job from requester 2
    msg_addr[2*ADDR_W +: ADDR_W] = 16'h0000;
    out_addr[2*ADDR_W +: ADDR_W] = 16'h0100;
    t0  = cycle;
    req = 4'b0100;
    @(negedge clk);
    check_vec("single_start", {31'd0, eng_start}, 32'd1);
    check_vec("single_msg",   {16'd0, eng_message_addr}, 32'h0000);
    check_vec("single_out",   {16'd0, eng_output_addr}, 32'h0100);
    check_vec("single_gid",   {30'd0, grant_id}, 32'd2);
    check_vec("single_busy",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_vec("single_start_1cyc", {31'd0, eng_start}, 32'd0);
    wait_resp();
    check_vec("single_lat",  cycle - t0, 32'd9);
    check_vec("single_ack",  {28'd0, ack}, 32'b0100);
    check_vec("single_jobs", {16'd0, jobs_done}, 32'd1);
    req = '0;
    @(negedge clk);
    check_vec("single_ack_1cyc", {28'd0, ack}, 32'd0);
    check_vec("single_idle",     {31'd0, busy}, 32'd0);

    // contention: all four held from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      msg_addr[i*ADDR_W +: ADDR_W] = 16'h1000 + 16'(i);
      out_addr[i*ADDR_W +: ADDR_W] = 16'h2000 + 16'(i);
    end
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_start();
      check_vec("cont_gid", {30'd0, grant_id}, 32'(j % 4));
      check_vec("cont_msg", {16'd0, eng_message_addr}, 32'h1000 + 32'(j % 4));
      check_vec("cont_out", {16'd0, eng_output_addr}, 32'h2000 + 32'(j % 4));
      wait_resp();
      check_vec("cont_ack", {28'd0, ack}, 32'd1 << (j % 4));
      if (j == 4) req = '0;
    end
    check_vec("cont_jobs", {16'd0, jobs_done}, 32'd5);
    repeat (3) @(negedge clk);
    check_vec("cont_drain", {31'd0, busy}, 32'd0);

    // fairness wrap: move pointer to 3, then 3 and 0 request together
    req = 4'b0100;
    wait_start();
    check_vec("wrap_pre_gid", {30'd0, grant_id}, 32'd2);
    wait_resp();
    req = '0;
    @(negedge clk);
    req = 4'b1001;
    wait_start();
    check_vec("wrap_first", {30'd0, grant_id}, 32'd3);
    wait_resp();
    check_vec("wrap_ack3", {28'd0, ack}, 32'b1000);
    req = 4'b0001;
    wait_start();
    check_vec("wrap_second", {30'd0, grant_id}, 32'd0);
    wait_resp();
    check_vec("wrap_ack0", {28'd0, ack}, 32'b0001);
    req = '0;
    @(negedge clk);

    // engine ignores start: busy watchdog fires
    eng_mode = MODE_IGNORE;
    t0  = cycle;
    req = 4'b0010;
    wait_resp();
    check_vec("busy_to_lat", cycle - t0, 32'(BUSY_TIMEOUT + 3));
    check_vec("busy_to_err", {28'd0, err}, 32'b0010);
    check_vec("busy_to_ack", {28'd0, ack}, 32'd0);
    check_vec("busy_to_idle", {31'd0, busy}, 32'd0);
    req = '0;
    eng_mode = MODE_NORMAL;
    @(negedge clk);
    req = 4'b0100;
    wait_start();
    check_vec("after_to_gid", {30'd0, grant_id}, 32'd2);
    wait_resp();
    check_vec("after_to_ack", {28'd0, ack}, 32'b0100);
    check_vec("after_to_jobs", {16'd0, jobs_done}, 32'd9);
    req = '0;
    @(negedge clk);

    // hung engine: done never returns
    eng_mode = MODE_HANG;
    t0  = cycle;
    req = 4'b1000;
    wait_resp();
    check_vec("hang_lat", cycle - t0, 32'(TIMEOUT + 4));
    check_vec("hang_err", {28'd0, err}, 32'b1000);
    check_vec("hang_ack", {28'd0, ack}, 32'd0);
    req = 4'b0001;
    nst = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (eng_start) nst++;
    end
    check_vec("hang_no_restart", nst, 32'd0);
    check_vec("hang_jobs", {16'd0, jobs_done}, 32'd9);
    req = '0;

    // reset mid-job, then requester 0 priority restored
    eng_mode = MODE_NORMAL;
    eng_lat  = 20;
    do_reset();
    req = 4'b0100;
    wait_start();
    wait_resp();
    req = '0;
    @(negedge clk);
    req = 4'b1000;
    wait_start();
    check_vec("midrst_gid", {30'd0, grant_id}, 32'd3);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_vec("midrst_start",  {31'd0, eng_start}, 32'd0);
    check_vec("midrst_ackerr", {24'd0, ack, err}, 32'd0);
    check_vec("midrst_busy",   {31'd0, busy}, 32'd0);
    check_vec("midrst_jobs",   {16'd0, jobs_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1001;
    wait_start();
    check_vec("postrst_gid", {30'd0, grant_id}, 32'd0);
    wait_resp();
    check_vec("postrst_ack",  {28'd0, ack}, 32'b0001);
    check_vec("postrst_jobs", {16'd0, jobs_done}, 32'd1);
    req = '0;
    repeat (2) @(negedge clk);

    check_vec("ackerr_onehot", multi, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_job_arbiter.md
Name: sha256_job_arbiter

Overview:
- Shares one simplified SHA-256 engine between N_REQ independent requesters.
- Each requester posts a job: a message address plus an output address.
- The arbiter grants jobs round-robin, drives the engine's start and address inputs, and tracks engine done.
- It returns a one-cycle ack per completed job, or a one-cycle err if the engine hangs. It sits between the requesters and the engine's control pins; the engine keeps sole ownership of the memory port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, word-address width, equal to the engine's message_addr/output_addr width.
- TIMEOUT, 2048, maximum cycles in WAIT_DONE before a job is declared hung.
- BUSY_TIMEOUT, 4, maximum cycles in WAIT_BUSY for eng_done to fall after start.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester job request, level.
- msg_addr  in  N_REQ*ADDR_W  per-requester message address; slice i belongs to requester i.
- out_addr  in  N_REQ*ADDR_W  per-requester output address.
- ack  out  N_REQ  one-cycle pulse: job complete.
- err  out  N_REQ  one-cycle pulse: job timed out.
- eng_start  out  1  start pulse to the engine.
- eng_message_addr  out  ADDR_W  latched message address for the engine.
- eng_output_addr  out  ADDR_W  latched output address for the engine.
- eng_done  in  1  engine idle flag (high whenever the engine is idle, including before the first job).
- busy  out  1  a job is in flight (state is not IDLE).
- grant_id  out  max(1,$clog2(N_REQ))  index of the current or last granted requester.
- jobs_done  out  16  count of acked jobs, saturating.

Behaviour:
- Reset values (async on reset_n low): state IDLE; eng_start 0; eng_*_addr 0; ack 0; err 0; busy 0; grant_id 0; jobs_done 0; rr pointer 0.
- After reset, requester 0 has highest priority.
- All outputs are registered.
- Requester contract:
  - Hold req, msg_addr[i] and out_addr[i] stable until ack[i] or err[i].
  - Addresses are sampled only at grant.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - When |req and eng_done are both 1, pick the first requesting index at or after the rr pointer, wrapping modulo N_REQ.
  - Latch grant_id and that requester's addresses; next state ISSUE.
  - If eng_done is 0 (engine still recovering from a timeout), do not grant.
- ISSUE:
  - eng_start = 1 for exactly this one cycle; next state WAIT_BUSY; clear the watchdog.
  - Latency: req sampled at edge k puts eng_start high in cycle k..k+1.
- WAIT_BUSY:
  - On eng_done == 0, go to WAIT_DONE and clear the watchdog.
  - If the watchdog reaches BUSY_TIMEOUT: err[grant_id] = 1 for one cycle, rr pointer = grant_id+1 mod N_REQ, go to IDLE.
- WAIT_DONE:
  - On eng_done == 1, go to RESP.
  - On watchdog == TIMEOUT, raise the same err pulse and pointer update as in WAIT_BUSY, then go to IDLE.
  - The engine is not restarted; IDLE waits for eng_done before the next grant.
- RESP:
  - ack[grant_id] = 1 for one cycle.
  - jobs_done += 1, holding at 16'hFFFF (no wrap).
  - rr pointer = grant_id+1 mod N_REQ; next state IDLE.
  - The earliest next eng_start is 2 cycles after the ack cycle.
- The watchdog is 16-bit and saturating; TIMEOUT must be < 65535.
- Boundary conditions:
  - req dropped mid-job: the job completes and ack still pulses; the requester ignores it.
  - req dropped before grant: that requester is not served.
  - Simultaneous requests: exactly one grant per job; a requester never waits more than N_REQ-1 other jobs.
  - Single requester holding req: served back-to-back, one job per (engine time + 4) cycles.
  - eng_done glitching high during WAIT_BUSY is ignored; only the fall is checked.
- Reset mid-job: all state and outputs return to reset values; no ack or err is issued for the aborted job; the engine is reset by the same reset_n.
- At most one bit of ack|err is high in any cycle.

Decomposition:
- Package sha256_ctrl_pkg holds:
  - the state enum type for IDLE..RESP;
  - the ADDR_W default (16) and DATA_W (32);
  - the jobs_done width constant.
- Sub-module rr_pick: combinational; inputs req[N_REQ] and ptr; outputs valid and idx. This is the round-robin search, reusable by other shared blocks.

Test Plan:
- Single job: requester 2 raises req with msg_addr 16'h0000, out_addr 16'h0100, engine idle → eng_start pulses 1 cycle later with eng_message_addr 16'h0000 and eng_output_addr 16'h0100. When the engine writes 8 hash words and raises done, ack[2] pulses once, jobs_done = 1, and memory at 0x100..0x107 matches the golden SHA-256 of a 20-word message.
- Contention: req = 4'b1111 from reset, all held → grant order 0,1,2,3,0; each ack one-hot; jobs_done = 5.
- Fairness wrap: pointer at 3 and req = 4'b1001 → grant order 3 then 0, not 0 first.
- Hung engine: stub holds eng_done = 0 forever after start → err[grant] pulses exactly TIMEOUT+1 cycles after WAIT_DONE entry, no ack, and no further eng_start while eng_done stays 0.
- Engine ignores start: stub keeps eng_done = 1 → err pulses after BUSY_TIMEOUT cycles in WAIT_BUSY; the next request is granted normally.
- Reset mid-job: assert reset_n low during WAIT_DONE → eng_start, ack, err, busy and jobs_done are 0 immediately. After release, a new req is served from requester 0 priority.
